// File: rtl/counter_pkg.sv
// counter_pkg -- shared constants for the multi-mode counter.
//   DIR_UP / DIR_DOWN   : encoding of the dir input.
//   MODE_WRAP / MODE_SAT: encoding of the SAT parameter.
package counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/cnt_next_calc.sv
// cnt_next_calc -- purely combinational next-count and boundary-event logic.
// Ports:
//   cnt      (in,  WIDTH)  : current count, assumed <= MAX_VAL
//   dir      (in,  1)      : 0 = up, 1 = down
//   step     (in,  STEP_W) : step amount
//   next_cnt (out, WIDTH)  : count after one step
//   boundary (out, 1)      : step crossed or hit-and-pushed-against a limit
// Parameters: WIDTH, MAX_VAL, STEP_W, SAT (0 = wrap, 1 = saturate).
module cnt_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP_W  = 2,
  parameter int SAT     = 0
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  next_cnt,
  output logic              boundary
);

  // All arithmetic is done one bit wider than the count so a carry out of
  // an up step and the modulus itself (MAX_VAL+1) are representable.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;

  assign cnt_ext  = {1'b0, cnt};
  assign step_ext = (WIDTH+1)'(step);
  assign sum      = cnt_ext + step_ext;

  always_comb begin
    next_cnt = cnt;
    boundary = 1'b0;
    if (dir == DIR_UP) begin
      if (sum > MAX_EXT) begin
        boundary = 1'b1;
        if (SAT == MODE_SAT) next_cnt = MAX_CNT;
        else                 next_cnt = WIDTH'(sum - MOD_EXT);
      end else begin
        next_cnt = sum[WIDTH-1:0];
      end
    end else begin
      if (cnt_ext >= step_ext) begin
        next_cnt = WIDTH'(cnt_ext - step_ext);
      end else begin
        boundary = 1'b1;
        // cnt < step, so cnt+MOD-step is below MOD and fits in WIDTH bits.
        if (SAT == MODE_SAT) next_cnt = '0;
        else                 next_cnt = WIDTH'(cnt_ext + MOD_EXT - step_ext);
      end
    end
  end

endmodule : cnt_next_calc

// File: rtl/multi_mode_counter.sv
// multi_mode_counter -- loadable up/down counter with programmable modulus,
// variable step, wrap or saturate boundary handling, terminal-count pulse
// and sticky overflow flag.
// Optional feature macro: COUNTER_CAPTURE_EN (adds a capture register
// loaded from the pre-edge count when cap is high).
// Ports:
//   clk     (in)         : clock, rising edge
//   rst     (in)         : synchronous reset, active low
//   load    (in)         : load cnt_in (clamped to MAX_VAL)
//   enab    (in)         : count enable
//   dir     (in)         : 0 = up, 1 = down
//   step    (in, STEP_W) : step amount; 0 holds
//   cnt_in  (in, WIDTH)  : load value
//   clr_ovf (in)         : clear sticky overflow
//   cap     (in)         : capture strobe
//   cnt_out (out, WIDTH) : registered count
//   tc      (out)        : one-cycle pulse after a boundary event
//   ovf     (out)        : sticky boundary flag
//   cap_out (out, WIDTH) : captured count (0 without COUNTER_CAPTURE_EN)
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP_W  = 2,
  parameter int SAT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enab,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clr_ovf,
  input  logic              cap,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              tc,
  output logic              ovf,
  output logic [WIDTH-1:0]  cap_out
);

  generate
    if ((MAX_VAL > (2**WIDTH) - 1) || (MAX_VAL < 1) || ((2**STEP_W) - 1 > MAX_VAL)) begin : g_param_err
      $error("multi_mode_counter: illegal WIDTH/MAX_VAL/STEP_W combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_reg;
  logic             tc_reg;
  logic             ovf_reg;
  logic [WIDTH-1:0] calc_next;
  logic             calc_boundary;
  logic [WIDTH-1:0] load_val;
  logic             count_en;
  logic             event_hit;

  cnt_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP_W  (STEP_W),
    .SAT     (SAT)
  ) u_calc (
    .cnt      (cnt_reg),
    .dir      (dir),
    .step     (step),
    .next_cnt (calc_next),
    .boundary (calc_boundary)
  );

  // Load has priority over counting; a zero step is a plain hold.
  assign load_val  = (cnt_in > MAX_CNT) ? MAX_CNT : cnt_in;
  assign count_en  = !load && enab && (step != '0);
  assign event_hit = count_en && calc_boundary;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      tc_reg <= event_hit;
      if (load)          cnt_reg <= load_val;
      else if (count_en) cnt_reg <= calc_next;
      // A new boundary event outranks a simultaneous clear.
      if (event_hit)     ovf_reg <= 1'b1;
      else if (clr_ovf)  ovf_reg <= 1'b0;
    end
  end

  assign cnt_out = cnt_reg;
  assign tc      = tc_reg;
  assign ovf     = ovf_reg;

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_reg;

  always_ff @(posedge clk) begin
    if (!rst)     cap_reg <= '0;
    else if (cap) cap_reg <= cnt_reg;
  end

  assign cap_out = cap_reg;
`else
  logic cap_unused;
  assign cap_unused = cap;
  assign cap_out    = '0;
`endif

endmodule : multi_mode_counter

// File: tb/tb_multi_mode_counter.sv
// Directed bench: one wrap-mode and one saturate-mode counter (WIDTH=5,
// MAX_VAL=9, STEP_W=2) share the same stimulus; each is checked against
// hand-computed values.
module tb_multi_mode_counter;

  logic       clk = 1'b0;
  logic       rst, load, enab, dir, clr_ovf, cap;
  logic [1:0] step;
  logic [4:0] cnt_in;
  logic [4:0] cnt_w, cap_w, cnt_s, cap_s;
  logic       tc_w, ovf_w, tc_s, ovf_s;
  logic [4:0] cap_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_mode_counter #(.WIDTH(5), .MAX_VAL(9), .STEP_W(2), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .load(load), .enab(enab), .dir(dir), .step(step),
    .cnt_in(cnt_in), .clr_ovf(clr_ovf), .cap(cap),
    .cnt_out(cnt_w), .tc(tc_w), .ovf(ovf_w), .cap_out(cap_w)
  );

  multi_mode_counter #(.WIDTH(5), .MAX_VAL(9), .STEP_W(2), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .load(load), .enab(enab), .dir(dir), .step(step),
    .cnt_in(cnt_in), .clr_ovf(clr_ovf), .cap(cap),
    .cnt_out(cnt_s), .tc(tc_s), .ovf(ovf_s), .cap_out(cap_s)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load = 0; enab = 0; dir = 0; step = 0; cnt_in = 0; clr_ovf = 0; cap = 0;
  endtask

  task automatic load_both(input logic [4:0] v);
    idle(); load = 1; cnt_in = v; clr_ovf = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); rst = 0;
    tick(); tick();
    checks += 8;
    if (cnt_w !== 5'd0) begin errors++; $display("FAIL reset_cnt_w got %0d want 0", cnt_w); end
    if (tc_w  !== 1'b0) begin errors++; $display("FAIL reset_tc_w got %b want 0", tc_w); end
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL reset_ovf_w got %b want 0", ovf_w); end
    if (cap_w !== 5'd0) begin errors++; $display("FAIL reset_cap_w got %0d want 0", cap_w); end
    if (cnt_s !== 5'd0) begin errors++; $display("FAIL reset_cnt_s got %0d want 0", cnt_s); end
    if (tc_s  !== 1'b0) begin errors++; $display("FAIL reset_tc_s got %b want 0", tc_s); end
    if (ovf_s !== 1'b0) begin errors++; $display("FAIL reset_ovf_s got %b want 0", ovf_s); end
    if (cap_s !== 5'd0) begin errors++; $display("FAIL reset_cap_s got %0d want 0", cap_s); end
    rst = 1;
    $display("reset: cnt_w=%0d cnt_s=%0d", cnt_w, cnt_s);
  endtask

  task automatic test_wrap_up();
    load_both(5'd8);
    checks += 3;
    if (cnt_w !== 5'd8) begin errors++; $display("FAIL load8_cnt_w got %0d want 8", cnt_w); end
    if (tc_w  !== 1'b0) begin errors++; $display("FAIL load8_tc_w got %b want 0", tc_w); end
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL load8_ovf_w got %b want 0", ovf_w); end
    enab = 1; dir = 0; step = 2'd3;
    tick();
    checks += 6;
    if (cnt_w !== 5'd1) begin errors++; $display("FAIL up_wrap_cnt got %0d want 1", cnt_w); end
    if (tc_w  !== 1'b1) begin errors++; $display("FAIL up_wrap_tc got %b want 1", tc_w); end
    if (ovf_w !== 1'b1) begin errors++; $display("FAIL up_wrap_ovf got %b want 1", ovf_w); end
    if (cnt_s !== 5'd9) begin errors++; $display("FAIL up_sat_cnt got %0d want 9", cnt_s); end
    if (tc_s  !== 1'b1) begin errors++; $display("FAIL up_sat_tc got %b want 1", tc_s); end
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL up_sat_ovf got %b want 1", ovf_s); end
    idle();
    tick();
    checks += 4;
    if (tc_w  !== 1'b0) begin errors++; $display("FAIL tc_w_one_cycle got %b want 0", tc_w); end
    if (ovf_w !== 1'b1) begin errors++; $display("FAIL ovf_w_sticky got %b want 1", ovf_w); end
    if (cnt_w !== 5'd1) begin errors++; $display("FAIL hold_cnt_w got %0d want 1", cnt_w); end
    if (tc_s  !== 1'b0) begin errors++; $display("FAIL tc_s_one_cycle got %b want 0", tc_s); end
    $display("wrap_up: cnt_w=%0d cnt_s=%0d ovf_w=%b", cnt_w, cnt_s, ovf_w);
  endtask

  task automatic test_wrap_down();
    idle(); clr_ovf = 1;
    tick();
    checks += 2;
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL clr_ovf_w got %b want 0", ovf_w); end
    if (ovf_s !== 1'b0) begin errors++; $display("FAIL clr_ovf_s got %b want 0", ovf_s); end
    load_both(5'd1);
    enab = 1; dir = 1; step = 2'd2;
    tick();
    checks += 6;
    if (cnt_w !== 5'd9) begin errors++; $display("FAIL dn_wrap_cnt got %0d want 9", cnt_w); end
    if (tc_w  !== 1'b1) begin errors++; $display("FAIL dn_wrap_tc got %b want 1", tc_w); end
    if (ovf_w !== 1'b1) begin errors++; $display("FAIL dn_wrap_ovf got %b want 1", ovf_w); end
    if (cnt_s !== 5'd0) begin errors++; $display("FAIL dn_sat_cnt got %0d want 0", cnt_s); end
    if (tc_s  !== 1'b1) begin errors++; $display("FAIL dn_sat_tc got %b want 1", tc_s); end
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL dn_sat_ovf got %b want 1", ovf_s); end
    // Plain down step without crossing: 9-2=7 in wrap mode; sat pinned at 0 -> event.
    tick();
    checks += 3;
    if (cnt_w !== 5'd7) begin errors++; $display("FAIL dn_plain_cnt got %0d want 7", cnt_w); end
    if (tc_w  !== 1'b0) begin errors++; $display("FAIL dn_plain_tc got %b want 0", tc_w); end
    if (tc_s  !== 1'b1) begin errors++; $display("FAIL dn_sat_at0_tc got %b want 1", tc_s); end
    idle();
    $display("wrap_down: cnt_w=%0d cnt_s=%0d", cnt_w, cnt_s);
  endtask

  task automatic test_saturate();
    load_both(5'd8);
    enab = 1; dir = 0; step = 2'd3;
    tick();
    checks += 2;
    if (cnt_s !== 5'd9) begin errors++; $display("FAIL sat1_cnt got %0d want 9", cnt_s); end
    if (tc_s  !== 1'b1) begin errors++; $display("FAIL sat1_tc got %b want 1", tc_s); end
    tick();
    checks += 6;
    if (cnt_s !== 5'd9) begin errors++; $display("FAIL sat2_cnt got %0d want 9", cnt_s); end
    if (tc_s  !== 1'b1) begin errors++; $display("FAIL sat2_tc got %b want 1", tc_s); end
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat2_ovf got %b want 1", ovf_s); end
    if (cnt_w !== 5'd4) begin errors++; $display("FAIL wrap_1p3_cnt got %0d want 4", cnt_w); end
    if (tc_w  !== 1'b0) begin errors++; $display("FAIL wrap_1p3_tc got %b want 0", tc_w); end
    if (ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_ovf_sticky got %b want 1", ovf_w); end
    idle();
    tick();
    checks += 1;
    if (tc_s !== 1'b0) begin errors++; $display("FAIL sat_tc_drop got %b want 0", tc_s); end
    $display("saturate: cnt_s=%0d ovf_s=%b", cnt_s, ovf_s);
  endtask

  task automatic test_priority_clamp();
    idle(); clr_ovf = 1;
    tick();
    idle(); load = 1; enab = 1; dir = 0; step = 2'd3; cnt_in = 5'd15;
    tick();
    checks += 4;
    if (cnt_w !== 5'd9) begin errors++; $display("FAIL clamp_cnt_w got %0d want 9", cnt_w); end
    if (tc_w  !== 1'b0) begin errors++; $display("FAIL clamp_tc_w got %b want 0", tc_w); end
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL clamp_ovf_w got %b want 0", ovf_w); end
    if (cnt_s !== 5'd9) begin errors++; $display("FAIL clamp_cnt_s got %0d want 9", cnt_s); end
    // Boundary event and clr_ovf on the same edge: set wins.
    idle(); enab = 1; dir = 0; step = 2'd1; clr_ovf = 1;
    tick();
    checks += 4;
    if (cnt_w !== 5'd0) begin errors++; $display("FAIL setwins_cnt_w got %0d want 0", cnt_w); end
    if (ovf_w !== 1'b1) begin errors++; $display("FAIL setwins_ovf_w got %b want 1", ovf_w); end
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL setwins_ovf_s got %b want 1", ovf_s); end
    if (tc_w  !== 1'b1) begin errors++; $display("FAIL setwins_tc_w got %b want 1", tc_w); end
    idle();
    $display("priority_clamp: cnt_w=%0d ovf_w=%b", cnt_w, ovf_w);
  endtask

  task automatic test_step_zero();
    load_both(5'd5);
    enab = 1; dir = 0; step = 2'd0;
    tick();
    checks += 4;
    if (cnt_w !== 5'd5) begin errors++; $display("FAIL step0_cnt_w got %0d want 5", cnt_w); end
    if (tc_w  !== 1'b0) begin errors++; $display("FAIL step0_tc_w got %b want 0", tc_w); end
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL step0_ovf_w got %b want 0", ovf_w); end
    if (cnt_s !== 5'd5) begin errors++; $display("FAIL step0_cnt_s got %0d want 5", cnt_s); end
    idle();
    $display("step_zero: cnt_w=%0d", cnt_w);
  endtask

  task automatic test_reset_mid();
    load_both(5'd9);
    enab = 1; dir = 0; step = 2'd1;
    tick();
    checks += 1;
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL pre_rst_ovf_s got %b want 1", ovf_s); end
    // Sat counter at 9 would raise another event on this edge; reset must win.
    rst = 0; load = 1; cnt_in = 5'd4; cap = 1;
    tick();
    checks += 6;
    if (cnt_w !== 5'd0) begin errors++; $display("FAIL rstmid_cnt_w got %0d want 0", cnt_w); end
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL rstmid_ovf_w got %b want 0", ovf_w); end
    if (cnt_s !== 5'd0) begin errors++; $display("FAIL rstmid_cnt_s got %0d want 0", cnt_s); end
    if (tc_s  !== 1'b0) begin errors++; $display("FAIL rstmid_tc_s got %b want 0", tc_s); end
    if (ovf_s !== 1'b0) begin errors++; $display("FAIL rstmid_ovf_s got %b want 0", ovf_s); end
    if (cap_s !== 5'd0) begin errors++; $display("FAIL rstmid_cap_s got %0d want 0", cap_s); end
    rst = 1; idle();
    $display("reset_mid: cnt_s=%0d tc_s=%b", cnt_s, tc_s);
  endtask

  task automatic test_capture();
    load_both(5'd6);
    cap = 1; enab = 1; dir = 0; step = 2'd1;
    tick();
`ifdef COUNTER_CAPTURE_EN
    cap_exp = 5'd6;
`else
    cap_exp = 5'd0;
`endif
    checks += 3;
    if (cnt_w !== 5'd7)    begin errors++; $display("FAIL cap_cnt_w got %0d want 7", cnt_w); end
    if (cap_w !== cap_exp) begin errors++; $display("FAIL cap_out_w got %0d want %0d", cap_w, cap_exp); end
    if (cap_s !== cap_exp) begin errors++; $display("FAIL cap_out_s got %0d want %0d", cap_s, cap_exp); end
    cap = 0;
    tick();
    checks += 2;
    if (cnt_w !== 5'd8)    begin errors++; $display("FAIL cap_hold_cnt got %0d want 8", cnt_w); end
    if (cap_w !== cap_exp) begin errors++; $display("FAIL cap_hold_w got %0d want %0d", cap_w, cap_exp); end
    idle();
    $display("capture: cnt_w=%0d cap_w=%0d", cnt_w, cap_w);
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_w [4] = '{5'd9, 5'd1, 5'd3, 5'd5};
    logic       exp_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    load_both(5'd7);
    enab = 1; dir = 0; step = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 2;
      if (cnt_w !== exp_w[i]) begin errors++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, cnt_w, exp_w[i]); end
      if (tc_w  !== exp_t[i]) begin errors++; $display("FAIL b2b_tc[%0d] got %b want %b", i, tc_w, exp_t[i]); end
      $display("back_to_back[%0d]: cnt_w=%0d tc_w=%b", i, cnt_w, tc_w);
    end
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority_clamp();
    test_step_zero();
    test_reset_mid();
    test_capture();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multi_mode_counter

// File: doc/multi_mode_counter.md
MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 5, counter width in bits.
- MAX_VAL, 2**WIDTH-1, highest legal count; modulus is MAX_VAL+1.
- STEP_W, 2, width of the step input.
- SAT, 0, boundary mode: 0 = wrap, 1 = saturate.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous reset, active-low.
- load, input, 1, load cnt_in.
- enab, input, 1, count enable.
- dir, input, 1, count direction: 0 = up, 1 = down.
- step, input, STEP_W, increment or decrement amount.
- cnt_in, input, WIDTH, load value.
- clr_ovf, input, 1, clear the sticky overflow flag.
- cap, input, 1, capture strobe (used only when COUNTER_CAPTURE_EN is defined).
- cnt_out, output, WIDTH, current count (registered).
- tc, output, 1, terminal-count pulse (registered).
- ovf, output, 1, sticky boundary flag.
- cap_out, output, WIDTH, captured count.
REQ-003 Elaboration SHALL fail if MAX_VAL > 2**WIDTH-1, MAX_VAL < 1, or 2**STEP_W-1 > MAX_VAL.

Function
REQ-004 Per-edge priority SHALL be: rst low, then load, then enab with step != 0, then hold.
REQ-005 On load, cnt_out SHALL take cnt_in one cycle later; a cnt_in value above MAX_VAL SHALL be clamped to MAX_VAL.
REQ-006 A load SHALL generate no tc and SHALL NOT set ovf.
REQ-007 An up count SHALL compute cnt_out+step in WIDTH+1 bits; a result at or below MAX_VAL SHALL be stored unchanged.
REQ-008 When an up-count result exceeds MAX_VAL, SAT=0 SHALL store result-(MAX_VAL+1) and SAT=1 SHALL store MAX_VAL; this is a boundary event.
REQ-009 A down count with cnt_out >= step SHALL store cnt_out-step.
REQ-010 A down count with cnt_out < step SHALL store cnt_out+MAX_VAL+1-step when SAT=0, or 0 when SAT=1; this is a boundary event.
REQ-011 enab with step=0 SHALL hold the count and generate no event.
REQ-012 In saturate mode, a further step while already at the limit (MAX_VAL up, 0 down) SHALL be a boundary event and SHALL hold the value.
REQ-013 tc SHALL pulse high for exactly one cycle, in the cycle after the edge that stored a boundary event; tc SHALL be low otherwise.
REQ-014 ovf SHALL set on any boundary event and clear on clr_ovf; when both occur in the same cycle, set SHALL win.
REQ-015 No output SHALL depend combinationally on any input.

Reset
REQ-016 With rst low at a clock edge, the next state SHALL be cnt_out=0, tc=0, ovf=0, cap_out=0, regardless of load, enab or cap.
REQ-017 A reset arriving mid-sequence SHALL suppress any pending tc for that edge.

Configuration
REQ-018 When the macro COUNTER_CAPTURE_EN is defined, cap high SHALL copy the pre-edge cnt_out into cap_out at the edge; with cap low, cap_out SHALL hold its value.
REQ-019 When COUNTER_CAPTURE_EN is undefined, cap SHALL be ignored, cap_out SHALL be constant 0, and no capture register SHALL be inferred.

Structure
REQ-020 Package counter_pkg SHALL hold the constants DIR_UP=0, DIR_DOWN=1, MODE_WRAP=0 and MODE_SAT=1.
REQ-021 The next-value and boundary-event computation SHALL be a combinational sub-module, cnt_next_calc, instantiated once; all state SHALL live in multi_mode_counter.

Verification
REQ-022 Wrap, up (WIDTH=5, MAX_VAL=9, SAT=0): load 8, enab, step=3 -> cnt_out=1, tc pulses one cycle later, ovf=1.
REQ-023 Wrap, down (same configuration): load 1, dir=1, step=2 -> cnt_out=9, tc pulses, ovf=1.
REQ-024 Saturate (SAT=1, MAX_VAL=9): start at 8, step=3 up for two cycles -> cnt_out=9 then 9, tc high on both following cycles, ovf stays 1.
REQ-025 Priority and clamp: load=1, enab=1, cnt_in=15 with MAX_VAL=9 -> cnt_out=9, no tc; then clr_ovf together with a boundary event -> ovf remains 1.
REQ-026 Reset mid-operation: rst low on the edge that would wrap -> cnt_out=0, tc=0, ovf=0, cap_out=0.
REQ-027 Capture (COUNTER_CAPTURE_EN defined): cap with cnt_out=6 and enab step=1 -> cap_out=6, cnt_out=7; with the macro undefined, cap_out stays 0.
